spike_event_monitor: RTL and testbench
======================================

# spike_event_monitor

Downstream consumer of the Hodgkin-Huxley neuron's `spike` level output. It converts the level into discrete spike events, enforces a refractory window, and timestamps each accepted event with its inter-spike interval (ISI). Events are buffered in a small FIFO behind a valid/ready handshake, and the block periodically reports a firing-rate count per programmable window. It sits between the neuron core and the readout/host interface.

## Interface
Parameters:
- `ISI_W`, 16, width of ISI stamp and ISI counter
- `COUNT_W`, 8, width of per-window spike count
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, ≥2
- `REFRACT_CYCLES`, 8, cycles after an accepted event during which new rising edges are ignored; 0 = no refractory

Ports:
- `clock` in 1: single clock, all logic on its rising edge
- `reset` in 1: asynchronous, active-high; all state cleared immediately
- `enable` in 1: 1 = detection and windowing active
- `spike` in 1: level from neuron core (registered there)
- `window_len` in 16: rate window length in cycles; 0 = rate reporting off
- `evt_ready` in 1: consumer accepts the head event
- `evt_valid` out 1: FIFO non-empty
- `evt_isi` out ISI_W: ISI of the head event
- `rate_valid` out 1: one-cycle pulse, `rate_count` updated
- `rate_count` out COUNT_W: accepted spikes in the last completed window
- `overflow` out 1: sticky, an event was dropped on a full FIFO

## Operation
- Edge detect: `spike_q` registers `spike`. A rising edge is `spike & ~spike_q`. `spike_q` updates regardless of `enable`.
- Acceptance: an edge is accepted when `enable`=1 and `refr_cnt`==0.
- On accept, `refr_cnt` loads REFRACT_CYCLES. It otherwise decrements to 0, including while `enable`=0.
- ISI counter: increments every cycle, saturating at all-ones. Reset value is all-ones.
- On accept, the pushed ISI is the current counter value, and the counter loads 1. The first event after reset therefore reports all-ones.
- FIFO push on accept.
  - If full and no pop in the same cycle: drop the event and set `overflow`.
  - If full with a simultaneous pop: accept the push, no drop.
- Pop when `evt_valid & evt_ready`. `evt_isi` always shows the head entry, which is stable while `evt_valid` is high and `evt_ready` is low.
- Window FSM states:
  - IDLE: entered when `enable`=0 or `window_len`=0.
  - COUNT: `win_cnt` runs 0..`window_len`-1.
- In COUNT, on the cycle where `win_cnt`==`window_len`-1:
  - `rate_count` ← spikes accepted in the window, including an accept in this same cycle, saturating at 2^COUNT_W-1.
  - `rate_valid`=1 for that cycle.
  - `win_cnt` and the spike accumulator clear.
- COUNT→IDLE clears `win_cnt` and the accumulator without a report. IDLE→COUNT starts at `win_cnt`=0.
- A change to `window_len` mid-window takes effect at the next comparison. If `win_cnt` ≥ new `window_len`-1, the window ends that cycle.
- `overflow` clears only on `reset`.

## Timing
- Reset values: `evt_valid`=0, `evt_isi`=0, `rate_valid`=0, `rate_count`=0, `overflow`=0. Also `spike_q`=0, `refr_cnt`=0, ISI counter all-ones, FIFO empty.
- `spike` rises after edge k → detected at edge k+1 → `evt_valid` high after edge k+1. Latency is 1 cycle.
- A spike level held high produces exactly one event.
- With REFRACT_CYCLES=R, the minimum spacing between accepted edges is R+1 cycles.
- `rate_valid` and `rate_count` are registered: both are visible the cycle after the window's last cycle.
- Reset asserted mid-operation empties the FIFO asynchronously. Any in-progress window is discarded.

## Structure
- Shared package `neuron_pkg` holds:
  - ISI_W and COUNT_W defaults.
  - the window FSM state typedef (IDLE, COUNT).
  - the ISI saturation constant.
- Sub-module `spike_event_fifo`: a parameterized sync FIFO with push/pop/full/empty and async reset. The top module holds edge detection, refractory, ISI and window logic.

## Test plan
- Reset, `enable`=1, `spike` high for 5 cycles from cycle 10, `evt_ready`=1 → exactly one event. `evt_valid` is high at cycle 11 with `evt_isi`=0xFFFF.
- REFRACT_CYCLES=8: single-cycle spikes at cycles 10, 14, 20 → events at 10 and 20 only. The second `evt_isi`=10.
- `evt_ready`=0, 6 spaced spikes → 4 events held, `overflow`=1. Releasing ready drains ISIs in order.
- `window_len`=100, spikes at window cycles 5, 50, 99 → `rate_valid` pulse with `rate_count`=3, including the cycle-99 spike.
- Drop `enable` at window cycle 40 → no `rate_valid`. Re-enabling restarts the count at 0.
- Assert `reset` mid-window with 2 FIFO entries → all outputs 0 immediately. The next spike reports ISI 0xFFFF.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron readout path.
// Holds the default stamp/count widths, the rate-window FSM state type and
// the ISI saturation constant used by the spike event monitor.
package neuron_pkg;

  localparam int ISI_W_DEF   = 16;
  localparam int COUNT_W_DEF = 8;

  // ISI counter parks here once it saturates; it is also the reset value,
  // so the first event after reset reports "no previous spike".
  localparam logic [ISI_W_DEF-1:0] ISI_SAT = '1;

  typedef enum logic {
    WIN_IDLE  = 1'b0,
    WIN_COUNT = 1'b1
  } win_state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Small synchronous FIFO for spike events.
// Ports:
//   clock, reset        : rising-edge clock, async active-high reset (empties FIFO)
//   push, push_data     : write request and data; ignored when full unless a pop
//                         happens in the same cycle
//   pop                 : read request; ignored when empty
//   head_data           : oldest entry (valid while empty=0)
//   full, empty         : occupancy flags
module spike_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is safe.
  assign do_push = push & (~full | do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spike_event_monitor.sv
// Spike event monitor: turns the neuron spike level into discrete events,
// applies a refractory window, stamps each accepted event with its
// inter-spike interval, buffers events in a FIFO and reports a firing-rate
// count per programmable window.
// Ports:
//   clock, reset   : rising-edge clock, async active-high reset
//   enable         : detection and rate windowing active
//   spike          : spike level from the neuron core
//   window_len     : rate window length in cycles, 0 = rate reporting off
//   evt_ready      : consumer takes the head event
//   evt_valid      : event available
//   evt_isi        : ISI of the head event (0 when no event)
//   rate_valid     : one-cycle pulse when rate_count is updated
//   rate_count     : accepted spikes in the last completed window
//   overflow       : sticky, an event was dropped on a full FIFO
//
// Rate window FSM:
//   state     | meaning
//   WIN_IDLE  | disabled or window_len=0; counter and accumulator held at 0
//   WIN_COUNT | win_cnt runs 0..window_len-1, report on the last cycle
module spike_event_monitor
  import neuron_pkg::*;
#(
  parameter int ISI_W          = ISI_W_DEF,
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRACT_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike,
  input  logic [15:0]        window_len,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [ISI_W-1:0]   evt_isi,
  output logic               rate_valid,
  output logic [COUNT_W-1:0] rate_count,
  output logic               overflow
);

  // At least one bit so REFRACT_CYCLES=0 still gives a legal counter.
  localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  logic               spike_q;
  logic [RW-1:0]      refr_cnt;
  logic [ISI_W-1:0]   isi_cnt;
  logic               rise;
  logic               accept;

  logic [ISI_W-1:0]   fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               evt_pop;

  win_state_t         state;
  win_state_t         state_next;
  logic [15:0]        win_cnt;
  logic [COUNT_W-1:0] acc;
  logic [COUNT_W-1:0] acc_inc;
  logic               win_active;
  logic               win_last;
  logic               win_done;
  logic               win_clear;

  // Edge detect and acceptance
  assign rise   = spike & ~spike_q;
  assign accept = rise & enable & (refr_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spike_q  <= 1'b0;
      refr_cnt <= '0;
      isi_cnt  <= '1;
      overflow <= 1'b0;
    end else begin
      spike_q <= spike;

      if (accept)
        refr_cnt <= RW'(REFRACT_CYCLES);
      else if (refr_cnt != '0)
        refr_cnt <= refr_cnt - 1'b1;

      // The stamp pushed on accept is the pre-reload value; reloading to 1
      // makes the next stamp equal the cycle distance between accepts.
      if (accept)
        isi_cnt <= {{(ISI_W-1){1'b0}}, 1'b1};
      else if (isi_cnt != '1)
        isi_cnt <= isi_cnt + 1'b1;

      if (accept && fifo_full && !evt_pop)
        overflow <= 1'b1;
    end
  end

  // Event FIFO
  assign evt_valid = ~fifo_empty;
  assign evt_pop   = evt_valid & evt_ready;
  // FIFO storage is not reset, so mask the head while empty.
  assign evt_isi   = evt_valid ? fifo_head : '0;

  spike_event_fifo #(
    .WIDTH (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (isi_cnt),
    .pop       (evt_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Rate window
  assign win_active = enable & (window_len != 16'd0);
  // ">=" so that shrinking window_len mid-window ends the window at once.
  assign win_last   = (win_cnt >= (window_len - 16'd1));
  assign acc_inc    = (accept && (acc != '1)) ? acc + 1'b1 : acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WIN_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    win_done   = 1'b0;
    win_clear  = 1'b0;
    case (state)
      WIN_IDLE: begin
        win_clear = 1'b1;
        if (win_active) state_next = WIN_COUNT;
      end
      WIN_COUNT: begin
        if (!win_active) begin
          state_next = WIN_IDLE;
          win_clear  = 1'b1;
        end else if (win_last) begin
          win_done  = 1'b1;
          win_clear = 1'b1;
        end
      end
      default: begin
        state_next = WIN_IDLE;
        win_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      rate_valid <= 1'b0;
      rate_count <= '0;
    end else begin
      rate_valid <= win_done;
      if (win_done) rate_count <= acc_inc;
      if (win_clear) begin
        win_cnt <= '0;
        acc     <= '0;
      end else begin
        win_cnt <= win_cnt + 16'd1;
        acc     <= acc_inc;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_monitor.sv
module tb_spike_event_monitor;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        spike;
  logic [15:0] window_len;
  logic        evt_ready;
  logic        evt_valid;
  logic [15:0] evt_isi;
  logic        rate_valid;
  logic [7:0]  rate_count;
  logic        overflow;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];
  int rate_q[$];

  spike_event_monitor #(
    .ISI_W          (16),
    .COUNT_W        (8),
    .FIFO_DEPTH     (4),
    .REFRACT_CYCLES (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .spike      (spike),
    .window_len (window_len),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_isi    (evt_isi),
    .rate_valid (rate_valid),
    .rate_count (rate_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event scoreboard: every handshake pops the next expected ISI.
  always @(negedge clock) begin
    if (!reset && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) check_val("evt_unexpected", {31'd0, evt_valid}, 32'd0);
      else check_val("evt_isi", {16'd0, evt_isi}, sb_q.pop_front());
    end
  end

  // Rate scoreboard: every rate_valid pulse pops the next expected count.
  always @(negedge clock) begin
    if (!reset && rate_valid) begin
      if (rate_q.size() == 0) check_val("rate_unexpected", {31'd0, rate_valid}, 32'd0);
      else check_val("rate_count", {24'd0, rate_count}, rate_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns just after posedge c-1 so the next driven input is sampled at edge c.
  task automatic wait_until(input int c);
    while (cyc < c - 1) tick();
  endtask

  // Spike rising edge sampled at posedge c, held hi cycles. exp_isi >= 0
  // means an event with that ISI is expected to reach the FIFO.
  task automatic pulse_at(input int c, input int hi, input int exp_isi);
    wait_until(c);
    spike = 1'b1;
    if (exp_isi >= 0) sb_q.push_back(exp_isi);
    repeat (hi) tick();
    spike = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_val(tag, sb_q.size(), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    spike      = 1'b0;
    enable     = 1'b0;
    window_len = 16'd0;
    evt_ready  = 1'b0;
    tick();
    tick();
    sb_q.delete();
    rate_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    int x;
    int wb;
    reset      = 1'b1;
    spike      = 1'b0;
    enable     = 1'b0;
    window_len = 16'd0;
    evt_ready  = 1'b0;
    #1;
    check_val("rst_evt_valid",  {31'd0, evt_valid},  0);
    check_val("rst_evt_isi",    {16'd0, evt_isi},    0);
    check_val("rst_rate_valid", {31'd0, rate_valid}, 0);
    check_val("rst_rate_count", {24'd0, rate_count}, 0);
    check_val("rst_overflow",   {31'd0, overflow},   0);

    // Held level gives one event, 1-cycle latency, first ISI saturated
    do_reset();
    enable = 1'b1; evt_ready = 1'b1;
    x = cyc;
    wait_until(x + 10);
    spike = 1'b1;
    sb_q.push_back(16'hFFFF);
    tick();
    check_val("t1_latency_valid", {31'd0, evt_valid}, 1);
    check_val("t1_first_isi", {16'd0, evt_isi}, 32'hFFFF);
    repeat (4) tick();
    spike = 1'b0;
    repeat (10) tick();
    drain("t1_drain", 20);
    check_val("t1_single_event_valid", {31'd0, evt_valid}, 0);

    // Refractory: 14 ignored, 20 accepted (ISI 10), gap 9 ok, gap 8 ignored
    do_reset();
    enable = 1'b1; evt_ready = 1'b1;
    x = cyc;
    pulse_at(x + 10, 1, 16'hFFFF);
    pulse_at(x + 14, 1, -1);
    pulse_at(x + 20, 1, 10);
    pulse_at(x + 29, 1, 9);
    pulse_at(x + 37, 1, -1);
    pulse_at(x + 39, 1, 10);
    repeat (5) tick();
    drain("t2_drain", 20);

    // Overflow: four held, two dropped, drained in order
    do_reset();
    enable = 1'b1;
    x = cyc;
    pulse_at(x + 5,  1, 16'hFFFF);
    pulse_at(x + 17, 1, 12);
    pulse_at(x + 30, 1, 13);
    pulse_at(x + 44, 1, 14);
    tick();
    check_val("t3_ovf_before", {31'd0, overflow}, 0);
    check_val("t3_head_held", {16'd0, evt_isi}, 32'hFFFF);
    pulse_at(x + 59, 1, -1);
    pulse_at(x + 75, 1, -1);
    tick();
    check_val("t3_ovf_set", {31'd0, overflow}, 1);
    check_val("t3_head_stable", {16'd0, evt_isi}, 32'hFFFF);
    evt_ready = 1'b1;
    drain("t3_drain", 20);
    tick();
    check_val("t3_empty_after", {31'd0, evt_valid}, 0);
    check_val("t3_ovf_sticky", {31'd0, overflow}, 1);

    // Push into a full FIFO with a simultaneous pop: no drop
    do_reset();
    enable = 1'b1;
    x = cyc;
    pulse_at(x + 5,  1, 16'hFFFF);
    pulse_at(x + 15, 1, 10);
    pulse_at(x + 25, 1, 10);
    pulse_at(x + 35, 1, 10);
    wait_until(x + 45);
    spike = 1'b1;
    evt_ready = 1'b1;
    sb_q.push_back(10);
    tick();
    spike = 1'b0;
    drain("t3b_drain", 20);
    check_val("t3b_no_overflow", {31'd0, overflow}, 0);

    // Rate window of 100 with spikes at window cycles 5, 50, 99
    do_reset();
    enable = 1'b1; evt_ready = 1'b1; window_len = 16'd100;
    wb = cyc;
    rate_q.push_back(3);
    pulse_at(wb + 7,  1, 16'hFFFF);
    pulse_at(wb + 52, 1, 45);
    check_val("t4_no_early_rate", {31'd0, rate_valid}, 0);
    pulse_at(wb + 101, 1, 49);
    check_val("t4_rate_valid", {31'd0, rate_valid}, 1);
    check_val("t4_rate_count", {24'd0, rate_count}, 3);
    tick();
    check_val("t4_rate_pulse_len", {31'd0, rate_valid}, 0);
    check_val("t4_rate_q", rate_q.size(), 0);

    // Disable mid-window: no report; re-enable counts from 0
    pulse_at(wb + 112, 1, 11);
    wait_until(wb + 142);
    enable = 1'b0;
    pulse_at(wb + 160, 1, -1);
    wait_until(wb + 300);
    enable = 1'b1;
    x = cyc;
    rate_q.push_back(2);
    pulse_at(x + 5,  1, (x + 5) - (wb + 112));
    pulse_at(x + 62, 1, 57);
    wait_until(x + 102);
    check_val("t5_rate_valid", {31'd0, rate_valid}, 1);
    check_val("t5_rate_count", {24'd0, rate_count}, 2);
    enable = 1'b0;
    tick();
    drain("t5_drain", 20);
    check_val("t5_rate_q", rate_q.size(), 0);

    // Asynchronous reset mid-window with two queued events
    do_reset();
    enable = 1'b1; window_len = 16'd10;
    x = cyc;
    rate_q.push_back(1);
    rate_q.push_back(1);
    pulse_at(x + 4,  1, 16'hFFFF);
    pulse_at(x + 15, 1, 11);
    wait_until(x + 26);
    check_val("t6_pre_valid", {31'd0, evt_valid}, 1);
    check_val("t6_pre_rate", {24'd0, rate_count}, 1);
    check_val("t6_rate_seen", rate_q.size(), 0);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check_val("t6_rst_evt_valid",  {31'd0, evt_valid},  0);
    check_val("t6_rst_evt_isi",    {16'd0, evt_isi},    0);
    check_val("t6_rst_rate_valid", {31'd0, rate_valid}, 0);
    check_val("t6_rst_rate_count", {24'd0, rate_count}, 0);
    check_val("t6_rst_overflow",   {31'd0, overflow},   0);
    tick();
    tick();
    reset = 1'b0;
    enable = 1'b1; evt_ready = 1'b1; window_len = 16'd0;
    x = cyc;
    pulse_at(x + 5, 1, 16'hFFFF);
    drain("t6_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
